// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and register index.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

endpackage

// File: rtl/rf_bypass_mux.sv
// Per-read-port selector: forwards the highest-index matching write port's data
// when bypassing is enabled, otherwise passes the stored register value through.
module rf_bypass_mux
    import cpu_types_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]           rsel,
    input  logic [NWR-1:0]          wen,
    input  logic [NWR-1:0][AW-1:0]  wsel,
    input  logic [NWR-1:0][DW-1:0]  wdat,
    input  logic [DW-1:0]           stored,
    output logic [DW-1:0]           rdat,
    output logic                    hit
);

    // Later ports overwrite earlier matches, so the highest index wins.
    always_comb begin
        hit  = 1'b0;
        rdat = stored;
        if (BYPASS != 0) begin
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && (wsel[j] == rsel)) begin
                    hit  = 1'b1;
                    rdat = wdat[j];
                end
            end
        end else begin
            hit  = 1'b0;
            rdat = stored;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with per-register reservation (busy) bits,
// optional write-to-read forwarding and a registered write-conflict flag.
module regfile_mp
    import cpu_types_pkg::*;
#(
    parameter int DW       = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NRD-1:0][AW-1:0]  rsel,
    output logic [NRD-1:0][DW-1:0]  rdat,
    output logic [NRD-1:0]          busy,
    input  logic [NWR-1:0]          wen,
    input  logic [NWR-1:0][AW-1:0]  wsel,
    input  logic [NWR-1:0][DW-1:0]  wdat,
    input  logic                    rsv_en,
    input  logic [AW-1:0]           rsv_sel,
    output logic                    wr_conflict
);

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            wr_conflict_q;
    logic            wr_conflict_d;
    logic [NWR-1:0]  wen_eff_s;
    logic            rsv_eff_s;
    logic [NRD-1:0]  hit_s;

    function automatic logic writable(input logic [AW-1:0] a);
        return !((ZERO_REG != 0) && (a == {AW{1'b0}}));
    endfunction

    // Writes and reservations aimed at a hardwired-zero register are dropped here,
    // so register 0 never changes, never goes busy and never conflicts.
    always_comb begin
        for (int j = 0; j < NWR; j++) begin
            wen_eff_s[j] = wen[j] && writable(wsel[j]);
        end
        rsv_eff_s = rsv_en && writable(rsv_sel);
    end

    // Next state: ascending port order gives the highest index priority; set beats clear on busy.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
        end
        busy_d        = busy_q;
        wr_conflict_d = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            if (wen_eff_s[j]) begin
                regs_d[wsel[j]] = wdat[j];
                busy_d[wsel[j]] = 1'b0;
            end else begin
                busy_d[wsel[j]] = busy_d[wsel[j]];
            end
            for (int k = j + 1; k < NWR; k++) begin
                if (wen_eff_s[j] && wen_eff_s[k] && (wsel[j] == wsel[k])) begin
                    wr_conflict_d = 1'b1;
                end else begin
                    wr_conflict_d = wr_conflict_d;
                end
            end
        end
        if (rsv_eff_s) begin
            busy_d[rsv_sel] = 1'b1;
        end else begin
            busy_d[rsv_sel] = busy_d[rsv_sel];
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= {DW{1'b0}};
            end
            busy_q        <= {NREG{1'b0}};
            wr_conflict_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        rf_bypass_mux #(
            .DW     (DW),
            .AW     (AW),
            .NWR    (NWR),
            .BYPASS (BYPASS)
        ) u_mux (
            .rsel   (rsel[i]),
            .wen    (wen_eff_s),
            .wsel   (wsel),
            .wdat   (wdat),
            .stored (regs_q[rsel[i]]),
            .rdat   (rdat[i]),
            .hit    (hit_s[i])
        );

        // An in-flight write to this register resolves its reservation this cycle.
        assign busy[i] = busy_q[rsel[i]] & ~hit_s[i];
    end

    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp (default parameters, BYPASS=1, ZERO_REG=1).
module tb_regfile_mp;

    logic             CLK;
    logic             nRST;
    logic [1:0][4:0]  rsel;
    logic [1:0][31:0] rdat;
    logic [1:0]       busy;
    logic [1:0]       wen;
    logic [1:0][4:0]  wsel;
    logic [1:0][31:0] wdat;
    logic             rsv_en;
    logic [4:0]       rsv_sel;
    logic             wr_conflict;

    typedef struct {
        string       name;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [1:0]  bsy;
        logic        conf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    regfile_mp dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .rsel        (rsel),
        .rdat        (rdat),
        .busy        (busy),
        .wen         (wen),
        .wsel        (wsel),
        .wdat        (wdat),
        .rsv_en      (rsv_en),
        .rsv_sel     (rsv_sel),
        .wr_conflict (wr_conflict)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: samples outputs on the falling edge, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".rdat0"}, rdat[0], e.r0);
                chk({e.name, ".rdat1"}, rdat[1], e.r1);
                chk({e.name, ".busy"}, {30'd0, busy}, {30'd0, e.bsy});
                chk({e.name, ".wr_conflict"}, {31'd0, wr_conflict}, {31'd0, e.conf});
            end
        end
    end

    task automatic drive(input logic [1:0] w, input logic [4:0] ws0, input logic [31:0] wd0,
                         input logic [4:0] ws1, input logic [31:0] wd1,
                         input logic re, input logic [4:0] rs,
                         input logic [4:0] r0s, input logic [4:0] r1s);
        wen     = w;
        wsel[0] = ws0;
        wdat[0] = wd0;
        wsel[1] = ws1;
        wdat[1] = wd1;
        rsv_en  = re;
        rsv_sel = rs;
        rsel[0] = r0s;
        rsel[1] = r1s;
    endtask

    task automatic expect_now(input string nm, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [1:0] eb, input logic ec);
        exp_t e;
        e.name = nm;
        e.r0   = e0;
        e.r1   = e1;
        e.bsy  = eb;
        e.conf = ec;
        exp_q.push_back(e);
    endtask

    task automatic step(input string nm, input logic [1:0] w,
                        input logic [4:0] ws0, input logic [31:0] wd0,
                        input logic [4:0] ws1, input logic [31:0] wd1,
                        input logic re, input logic [4:0] rs,
                        input logic [4:0] r0s, input logic [4:0] r1s,
                        input logic [31:0] e0, input logic [31:0] e1,
                        input logic [1:0] eb, input logic ec);
        drive(w, ws0, wd0, ws1, wd1, re, rs, r0s, r1s);
        expect_now(nm, e0, e1, eb, ec);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step("rst_read", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
                 5'(2 * i), 5'(2 * i + 1), 32'd0, 32'd0, 2'b00, 1'b0);
        end

        step("wr5_bypass", 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0,
             5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 2'b00, 1'b0);
        step("wr5_stored", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
             5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 2'b00, 1'b0);

        step("dual7_bypass", 2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0,
             5'd7, 5'd7, 32'h22, 32'h22, 2'b00, 1'b0);
        step("dual7_conf", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
             5'd7, 5'd7, 32'h22, 32'h22, 2'b00, 1'b1);
        step("dual7_clear", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
             5'd7, 5'd5, 32'h22, 32'hDEADBEEF, 2'b00, 1'b0);

        step("dual0_same", 2'b11, 5'd0, 32'h33, 5'd0, 32'h44, 1'b0, 5'd0,
             5'd0, 5'd7, 32'd0, 32'h22, 2'b00, 1'b0);
        step("dual0_after", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
             5'd0, 5'd7, 32'd0, 32'h22, 2'b00, 1'b0);

        step("rsv9_issue", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9,
             5'd9, 5'd5, 32'd0, 32'hDEADBEEF, 2'b00, 1'b0);
        step("rsv9_busy", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
             5'd9, 5'd5, 32'd0, 32'hDEADBEEF, 2'b01, 1'b0);
        step("wr9_forced", 2'b10, 5'd0, 32'd0, 5'd9, 32'h99, 1'b0, 5'd0,
             5'd9, 5'd5, 32'h99, 32'hDEADBEEF, 2'b00, 1'b0);
        step("wr9_cleared", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
             5'd9, 5'd5, 32'h99, 32'hDEADBEEF, 2'b00, 1'b0);

        step("rsv_wr9_same", 2'b01, 5'd9, 32'h55, 5'd0, 32'd0, 1'b1, 5'd9,
             5'd9, 5'd0, 32'h55, 32'd0, 2'b00, 1'b0);
        step("rsv_wr9_after", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
             5'd9, 5'd0, 32'h55, 32'd0, 2'b01, 1'b0);

        step("rsv0_issue", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd0,
             5'd0, 5'd9, 32'd0, 32'h55, 2'b10, 1'b0);
        step("rsv0_ignored", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
             5'd0, 5'd9, 32'd0, 32'h55, 2'b10, 1'b0);

        step("wr3_wr4", 2'b11, 5'd3, 32'hA5, 5'd4, 32'h44, 1'b0, 5'd0,
             5'd4, 5'd3, 32'h44, 32'hA5, 2'b00, 1'b0);
        step("rsv3_issue", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd3,
             5'd3, 5'd4, 32'hA5, 32'h44, 2'b00, 1'b0);
        step("rsv3_busy", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
             5'd3, 5'd9, 32'hA5, 32'h55, 2'b11, 1'b0);

        // Asynchronous reset between edges: outputs must clear before the next edge.
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd9);
        #1;
        nRST = 1'b0;
        expect_now("async_rst", 32'd0, 32'd0, 2'b00, 1'b0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        step("post_rst", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
             5'd3, 5'd9, 32'd0, 32'd0, 2'b00, 1'b0);

        // Reset lands while a write is pending; the write must be lost.
        drive(2'b01, 5'd3, 32'h77, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
        expect_now("midwr_bypass", 32'h77, 32'd0, 2'b00, 1'b0);
        @(negedge CLK);
        #1;
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        step("first_wr6", 2'b01, 5'd6, 32'h66, 5'd0, 32'd0, 1'b0, 5'd0,
             5'd3, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0);
        step("wr6_kept", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
             5'd6, 5'd3, 32'h66, 32'd0, 2'b00, 1'b0);

        repeat (2) @(posedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data width in bits.
REQ-002 The block SHALL have parameter NREG, default 32, meaning register count (power of two, >=2); AW = $clog2(NREG).
REQ-003 The block SHALL have parameter NRD, default 2, meaning number of read ports.
REQ-004 The block SHALL have parameter NWR, default 2, meaning number of write ports.
REQ-005 The block SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-006 The block SHALL have parameter ZERO_REG, default 1, meaning 1 = register 0 hardwired to zero.
REQ-007 The block SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-008 The block SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-009 The block SHALL have port rsel  input  NRD x AW  read address per read port.
REQ-010 The block SHALL have port rdat  output  NRD x DW  read data per read port.
REQ-011 The block SHALL have port busy  output  NRD  register at rsel[i] has a pending reservation.
REQ-012 The block SHALL have port wen  input  NWR  write enable per write port.
REQ-013 The block SHALL have port wsel  input  NWR x AW  write address per write port.
REQ-014 The block SHALL have port wdat  input  NWR x DW  write data per write port.
REQ-015 The block SHALL have port rsv_en  input  1  reserve destination register (issue-stage).
REQ-016 The block SHALL have port rsv_sel  input  AW  register to reserve.
REQ-017 The block SHALL have port wr_conflict  output  1  registered flag: previous cycle had two enabled writes to the same writable register.

Function
REQ-018 Reads SHALL be combinational: rdat[i] = stored value of rsel[i], zero latency.
REQ-019 Writes SHALL take effect at the rising CLK edge after wen[j] is sampled high; data is visible on rdat the following cycle.
REQ-020 With ZERO_REG=1, writes to address 0 SHALL be ignored, rdat SHALL be 0 and busy SHALL be 0 for address 0, and rsv_en to address 0 SHALL be ignored.
REQ-021 On simultaneous enabled writes to the same address, the highest-index port SHALL win.
REQ-022 In that case wr_conflict SHALL be 1 for exactly the next cycle.
REQ-023 Writes to address 0 with ZERO_REG=1 SHALL not raise wr_conflict.
REQ-024 With BYPASS=1, if an enabled write port targets rsel[i], rdat[i] SHALL be that port's wdat (highest-index match), else the stored value.
REQ-025 With BYPASS=0, rdat SHALL always be the stored value.
REQ-026 Each register SHALL have one busy bit: set at the edge where rsv_en=1 and rsv_sel selects it, cleared at the edge where any enabled write targets it.
REQ-027 When set and clear coincide on the same register, set SHALL win (newer reservation outstanding).
REQ-028 rsv_en on an already-busy register SHALL keep it busy; no counter or error.
REQ-029 busy[i] SHALL be busy bit of rsel[i]; with BYPASS=1 it SHALL be forced 0 when an enabled write targets rsel[i] this cycle.
REQ-030 Out-of-range addresses cannot occur (NREG power of two); no checking SHALL be implemented.

Reset
REQ-031 On nRST low, immediately and regardless of CLK, all registers SHALL be 0, all busy bits 0, and wr_conflict 0.
REQ-032 A reset asserted mid-write SHALL discard the write.
REQ-033 The first write SHALL be accepted at the first rising edge with nRST high.

Structure
REQ-034 Word and register-index typedefs SHALL come from cpu_types_pkg (word_t for DW=32, regbits_t); no new package content is needed.
REQ-035 One sub-module SHALL be used: rf_bypass_mux (one per read port; selects the winning write port or stored data and produces the bypass hit used by busy).
REQ-036 The register_file_if SHALL not be used.
REQ-037 Ports SHALL be plain parameterised arrays.

Verification
REQ-038 The bench SHALL cover: reset, then read all 32 registers -> all rdat 0, busy 0, wr_conflict 0.
REQ-039 The bench SHALL cover: wen[0]=1, wsel[0]=5, wdat=0xDEADBEEF, rsel[0]=5 same cycle -> rdat[0]=0xDEADBEEF (BYPASS=1) or 0 (BYPASS=0), and 0xDEADBEEF next cycle either way.
REQ-040 The bench SHALL cover: wen=2'b11, wsel[0]=wsel[1]=7, wdat 0x11/0x22 -> reg7=0x22, wr_conflict=1 for one cycle.
REQ-041 The bench SHALL cover: the same with both wsel=0 -> reg0 reads 0, wr_conflict=0.
REQ-042 The bench SHALL cover: rsv_en with rsv_sel=9 -> busy=1 when rsel=9 next cycle; write to 9 -> busy forced 0 that cycle (BYPASS=1) and busy bit clear after the edge.
REQ-043 The bench SHALL cover: rsv_en plus write to 9 in the same cycle -> busy stays 1.
REQ-044 The bench SHALL cover: reg3=0xA5, reg3 reserved, nRST pulsed low between edges -> rdat=0 and busy=0 immediately.
